// File: rtl/cx_issue_ctrl.sv
// Custom-instruction issue controller: credit-limited issue to a custom unit,
// destination-register scoreboard for hazards, and a result FIFO drained by writeback.
module cx_issue_ctrl #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_v,
  input  logic [4:0]      req_rd,
  input  logic [XLEN-1:0] req_data,
  output logic            req_ready,
  output logic            cu_in_v,
  output logic [4:0]      cu_rd,
  output logic [XLEN-1:0] cu_data,
  input  logic            cu_busy,
  input  logic            cu_out_v,
  input  logic [4:0]      cu_out_rd,
  input  logic [XLEN-1:0] cu_out_data,
  output logic            wb_v,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  input  logic            wb_ready,
  input  logic [4:0]      q_rs1,
  input  logic [4:0]      q_rs2,
  output logic            q_hazard,
  output logic            err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]     pending, pending_next;
  logic [CW-1:0]   inflight, count;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [4:0]      rd_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];

  logic accept, pop, res_ok, push, drop0, proto_err, fifo_full;

  assign fifo_full = (count == DEPTH_C);
  assign req_ready = !cu_busy && (inflight < DEPTH_C) &&
                     !((req_rd != 5'd0) && pending[req_rd]);
  assign accept    = req_v && req_ready;

  assign wb_v    = (count != '0);
  assign wb_rd   = rd_mem[rd_ptr];
  assign wb_data = data_mem[rd_ptr];
  assign pop     = wb_v && wb_ready;

  // A result with nothing in flight is a protocol violation and is never stored.
  assign res_ok    = cu_out_v && (inflight != '0);
  assign push      = res_ok && (cu_out_rd != 5'd0) && !fifo_full;
  assign drop0     = res_ok && (cu_out_rd == 5'd0);
  assign proto_err = cu_out_v && ((inflight == '0) || ((cu_out_rd != 5'd0) && fifo_full));

  assign q_hazard = ((q_rs1 != 5'd0) && pending[q_rs1]) ||
                    ((q_rs2 != 5'd0) && pending[q_rs2]);

  // WAW stalling guarantees the popped rd and the accepted rd never coincide.
  always_comb begin
    pending_next = pending;
    if (pop)
      pending_next[wb_rd] = 1'b0;
    if (accept && (req_rd != 5'd0))
      pending_next[req_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cu_in_v  <= 1'b0;
      cu_rd    <= '0;
      cu_data  <= '0;
      pending  <= '0;
      inflight <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      err      <= 1'b0;
    end else begin
      cu_in_v  <= accept;
      if (accept) begin
        cu_rd   <= req_rd;
        cu_data <= req_data;
      end
      pending  <= pending_next;
      inflight <= inflight + CW'(accept) - CW'(pop) - CW'(drop0);
      count    <= count + CW'(push) - CW'(pop);
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (proto_err)
        err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= cu_out_rd;
      data_mem[wr_ptr] <= cu_out_data;
    end
  end

endmodule

// File: tb/tb_cx_issue_ctrl.sv
// Randomized and directed bench for cx_issue_ctrl against a queue-based model
// of the custom unit, the result buffer and the register scoreboard.
module tb_cx_issue_ctrl;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_v;
  logic [4:0]      req_rd;
  logic [XLEN-1:0] req_data;
  logic            req_ready;
  logic            cu_in_v;
  logic [4:0]      cu_rd;
  logic [XLEN-1:0] cu_data;
  logic            cu_busy;
  logic            cu_out_v;
  logic [4:0]      cu_out_rd;
  logic [XLEN-1:0] cu_out_data;
  logic            wb_v;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_ready;
  logic [4:0]      q_rs1;
  logic [4:0]      q_rs2;
  logic            q_hazard;
  logic            err;

  cx_issue_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_v(req_v), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
    .cu_in_v(cu_in_v), .cu_rd(cu_rd), .cu_data(cu_data), .cu_busy(cu_busy),
    .cu_out_v(cu_out_v), .cu_out_rd(cu_out_rd), .cu_out_data(cu_out_data),
    .wb_v(wb_v), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_hazard(q_hazard), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          t;
  } op_t;

  // The unit holds issued ops until it returns them; the buffer holds returned ones.
  op_t         unit_q[$];
  op_t         fifo_q[$];
  bit          pend[32];
  bit          m_cu_v;
  logic [4:0]  m_cu_rd;
  logic [31:0] m_cu_data;
  bit          m_err;

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;
  int ret_pct  = 100;
  bit inject   = 1'b0;
  bit last_acc = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp)
      n_pass++;
    else
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic modelReset();
    unit_q.delete();
    fifo_q.delete();
    foreach (pend[i]) pend[i] = 1'b0;
    m_cu_v    = 1'b0;
    m_cu_rd   = '0;
    m_cu_data = '0;
    m_err     = 1'b0;
  endtask

  task automatic doReset(input int n);
    reset = 1'b1; req_v = 1'b0; req_rd = '0; req_data = '0; cu_busy = 1'b0;
    cu_out_v = 1'b0; cu_out_rd = '0; cu_out_data = '0; wb_ready = 1'b0;
    q_rs1 = '0; q_rs2 = '0;
    repeat (n) @(posedge clk);
    modelReset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One cycle: drive inputs at the falling edge, check, advance the model, cross the rising edge.
  task automatic applyStimulus(input bit rv, input logic [4:0] rd, input logic [31:0] d,
                               input bit busy, input bit wbr,
                               input logic [4:0] rs1, input logic [4:0] rs2);
    int  infl, pre_size;
    bit  exp_ready, exp_haz, exp_wbv, acc, from_unit;
    op_t tmp;
    req_v = rv; req_rd = rd; req_data = d; cu_busy = busy; wb_ready = wbr;
    q_rs1 = rs1; q_rs2 = rs2;
    cu_out_v = 1'b0; cu_out_rd = '0; cu_out_data = '0; from_unit = 1'b0;
    if (inject) begin
      cu_out_v = 1'b1; cu_out_rd = 5'd9; cu_out_data = 32'hdead;
    end else if (unit_q.size() > 0 && unit_q[0].t <= cyc && $urandom_range(99) < ret_pct) begin
      cu_out_v = 1'b1; cu_out_rd = unit_q[0].rd; cu_out_data = unit_q[0].data + 32'd1;
      from_unit = 1'b1;
    end
    #1;
    infl      = unit_q.size() + fifo_q.size();
    exp_ready = !busy && (infl < DEPTH) && !((rd != 0) && pend[rd]);
    exp_haz   = ((rs1 != 0) && pend[rs1]) || ((rs2 != 0) && pend[rs2]);
    exp_wbv   = (fifo_q.size() != 0);
    checkOutput("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
    checkOutput("q_hazard",  {31'b0, q_hazard},  {31'b0, exp_haz});
    checkOutput("wb_v",      {31'b0, wb_v},      {31'b0, exp_wbv});
    if (exp_wbv) begin
      checkOutput("wb_rd",   {27'b0, wb_rd},     {27'b0, fifo_q[0].rd});
      checkOutput("wb_data", wb_data,            fifo_q[0].data);
    end
    checkOutput("cu_in_v",   {31'b0, cu_in_v},   {31'b0, m_cu_v});
    checkOutput("cu_rd",     {27'b0, cu_rd},     {27'b0, m_cu_rd});
    checkOutput("cu_data",   cu_data,            m_cu_data);
    checkOutput("err",       {31'b0, err},       {31'b0, m_err});

    acc      = rv && exp_ready;
    pre_size = fifo_q.size();
    if (exp_wbv && wbr) begin
      pend[fifo_q[0].rd] = 1'b0;
      tmp = fifo_q.pop_front();
    end
    if (cu_out_v) begin
      if (infl == 0)
        m_err = 1'b1;
      else begin
        if (from_unit)
          tmp = unit_q.pop_front();
        if (cu_out_rd != 0) begin
          if (pre_size == DEPTH)
            m_err = 1'b1;
          else
            fifo_q.push_back('{cu_out_rd, cu_out_data, 0});
        end
      end
    end
    m_cu_v = acc;
    if (acc) begin
      if (rd != 0)
        pend[rd] = 1'b1;
      unit_q.push_back('{rd, d, cyc + 2});
      m_cu_rd   = rd;
      m_cu_data = d;
    end
    last_acc = acc;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit wbr, input logic [4:0] rs1);
    repeat (n) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, wbr, rs1, 5'd0);
  endtask

  task automatic issue(input logic [4:0] rd, input logic [31:0] d, input bit wbr);
    for (int k = 0; k < 60; k++) begin
      applyStimulus(1'b1, rd, d, 1'b0, wbr, rd, 5'd0);
      if (last_acc) break;
    end
    checkOutput("accept_timeout", {31'b0, last_acc}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;
    doReset(3);
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rst_wb_v",      {31'b0, wb_v},      32'd0);
    checkOutput("rst_err",       {31'b0, err},       32'd0);

    // Single op through an incrementing unit.
    ret_pct = 100;
    issue(5'd5, 32'h10, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (wb_v && !seen) begin
        checkOutput("single_wb_rd",   {27'b0, wb_rd}, 32'd5);
        checkOutput("single_wb_data", wb_data,        32'h11);
        seen = 1'b1;
      end
      idle(1, 1'b1, 5'd5);
    end
    checkOutput("single_seen", {31'b0, seen}, 32'd1);

    // Busy stall, then WAW stall on rd 5.
    repeat (3) applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 1'b1, 5'd3, 5'd0);
    issue(5'd5, 32'h20, 1'b0);
    repeat (4) applyStimulus(1'b1, 5'd5, 32'h30, 1'b0, 1'b0, 5'd5, 5'd0);
    issue(5'd5, 32'h30, 1'b1);
    idle(8, 1'b1, 5'd0);

    // Credit limit with writeback held off.
    for (int r = 1; r <= 4; r++) issue(5'(r), 32'(r * 16), 1'b0);
    repeat (6) applyStimulus(1'b1, 5'd6, 32'h60, 1'b0, 1'b0, 5'd1, 5'd4);
    issue(5'd6, 32'h60, 1'b1);
    idle(10, 1'b1, 5'd0);

    // rd 0 never buffers nor hazards.
    issue(5'd0, 32'd7, 1'b1);
    idle(5, 1'b1, 5'd0);

    // Ten back-to-back ops wrapping the buffer.
    for (int r = 1; r <= 10; r++) issue(5'(r + 10), 32'(r * 3), 1'b1);
    idle(10, 1'b1, 5'd0);

    // Result with nothing in flight.
    inject = 1'b1;
    idle(1, 1'b1, 5'd0);
    inject = 1'b0;
    checkOutput("err_set",    {31'b0, err},  32'd1);
    checkOutput("err_no_wbv", {31'b0, wb_v}, 32'd0);
    idle(2, 1'b1, 5'd0);

    // Reset with three ops in flight.
    ret_pct = 0;
    for (int r = 1; r <= 3; r++) issue(5'(r), 32'(r), 1'b0);
    doReset(1);
    q_rs1 = 5'd1; q_rs2 = 5'd2;
    #1;
    checkOutput("post_rst_err",       {31'b0, err},       32'd0);
    checkOutput("post_rst_wb_v",      {31'b0, wb_v},      32'd0);
    checkOutput("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("post_rst_hazard",    {31'b0, q_hazard},  32'd0);
    idle(4, 1'b1, 5'd1);

    // Random traffic.
    ret_pct = 50;
    for (int k = 0; k < 600; k++)
      applyStimulus($urandom_range(99) < 60, 5'($urandom_range(7)), $urandom,
                    $urandom_range(99) < 20, $urandom_range(99) < 70,
                    5'($urandom_range(7)), 5'($urandom_range(7)));
    ret_pct = 100;
    idle(20, 1'b1, 5'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cx_issue_ctrl.md
Name: cx_issue_ctrl

Overview:
Core-side initiator for the custom-instruction port. It accepts custom-op requests from the execute stage and issues them to a custom unit, honouring that unit's busy signal. It tracks pending destination registers in a scoreboard for hazard checks, and buffers returning results in a FIFO. A shared writeback port drains the FIFO, so the custom unit never needs backpressure.

Parameters:
XLEN, 32, data width of operand and result.
DEPTH, 4, result FIFO entries; also the maximum number of in-flight ops (power of 2, 2..16).

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req_v  input  1  execute stage presents a custom op
req_rd  input  5  destination register of the op
req_data  input  XLEN  operand
req_ready  output  1  op accepted this cycle when req_v&&req_ready
cu_in_v  output  1  issue strobe to custom unit
cu_rd  output  5  rd to custom unit
cu_data  output  XLEN  operand to custom unit
cu_busy  input  1  custom unit cannot take an op
cu_out_v  input  1  custom unit result valid (single-cycle pulse, no backpressure)
cu_out_rd  input  5  result rd
cu_out_data  input  XLEN  result data
wb_v  output  1  FIFO head valid for writeback
wb_rd  output  5  head rd
wb_data  output  XLEN  head data
wb_ready  input  1  writeback port granted; pops head when wb_v
q_rs1, q_rs2  input  5 each  decode-stage source registers
q_hazard  output  1  q_rs1 or q_rs2 (nonzero) has a pending custom op
err  output  1  sticky protocol error

Behaviour:
- Reset: clk/reset are synchronous, active-high. Reset clears cu_in_v, cu_rd, cu_data, the FIFO pointers, the inflight counter, the pending[31:0] scoreboard and err. wb_v=0 and q_hazard=0 out of reset. Reset mid-operation discards all in-flight state; no wb_v until new results arrive.
- inflight counter (0..DEPTH):
  - +1 on acceptance.
  - -1 on pop, or on receipt of a result with rd==0.
  - Simultaneous +1/-1 nets to 0.
- req_ready is combinational: !cu_busy && inflight<DEPTH && !(req_rd!=0 && pending[req_rd]). A WAW hazard stalls the op.
- Acceptance sets pending[req_rd] (rd≠0) at the clock edge.
- Issue is registered with 1-cycle latency: cu_in_v<=accepted; cu_rd/cu_data load only on acceptance and hold otherwise. cu_in_v is a one-cycle pulse per op; back-to-back issue is allowed.
- Result capture:
  - cu_out_v with rd≠0 writes {rd,data} at the FIFO tail.
  - rd==0 results are discarded, with inflight -1.
  - cu_out_v while inflight==0 sets err and is dropped.
  - A push while full (unreachable by credit rule) sets err and is dropped.
- Writeback:
  - wb_v = FIFO non-empty; wb_rd/wb_data = head.
  - A result is visible at wb_v the cycle after cu_out_v; there is no same-cycle bypass.
  - Pop on wb_v&&wb_ready clears pending[wb_rd] at the same edge.
  - Push and pop in the same cycle are both performed, and occupancy is unchanged.
- Results complete in the order returned by the unit; the FIFO preserves that order. Pointers wrap modulo DEPTH.
- Same-cycle pop of rd X and request for rd X: req_ready is still low (pending set); the request is accepted the following cycle.
- q_hazard is combinational: (q_rs1≠0 && pending[q_rs1]) || (q_rs2≠0 && pending[q_rs2]). The register being popped this cycle still reads as pending.
- err is only cleared by reset.

Test Plan:
- Single op: req rd=5, data=0x10 with an incrementing unit and wb_ready=1. Required: cu_in_v 1 cycle after acceptance; result 0x11 on wb at rd=5; pending[5] set while in flight, then clear; q_rs1=5 hazard high until the pop edge.
- Busy and WAW stall:
  - cu_busy=1 holds req_ready=0 with no cu_in_v.
  - A second req to rd=5 while rd=5 is pending stalls until the cycle after its pop.
- Credit full: DEPTH=4, wb_ready=0, issue rd=1..4. Required: a 5th req stalls (req_ready=0) and 4 results are buffered. Raising wb_ready pops 1,2,3,4 in order; the 5th is accepted the cycle after the first pop.
- rd=0: issue rd=0 data=7. Required: no wb_v, inflight returns to 0, no pending bit, q_rs1=0 never hazards.
- Simultaneous push/pop with FIFO wrap: 10 back-to-back ops with wb_ready=1. Required: all 10 written back in order with correct data; err=0.
- Protocol error and reset: inject cu_out_v with inflight=0. Required: err=1, no wb_v. Assert reset mid-stream with 3 ops in flight. Required: err=0, wb_v=0, pending=0, req_ready=1 the next cycle.
